// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter with byte/half read-modify-write
//
// Two requesters (A: ALU, B: load unit) share the single register-file write port.
// Word writes go straight to WR; byte and halfword writes first read the destination,
// merge the new low bits over the old value, then write the full word back.
// Writes to register 0 are accepted and dropped.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data/a_size requester A write channel
//   b_valid/b_ready/b_addr/b_data/b_size requester B write channel
//   rf_re/rf_raddr/rf_rdata             register-file read port (RMW only)
//   rf_we/rf_waddr/rf_wdata             register-file write port
//   busy                                FSM not idle
//   wr_count                            rf_we pulses since reset (wrapping)

module regfile_wb_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter bit INIT_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [1:0]        a_size,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic [1:0]        b_size,
    output logic              rf_re,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {IDLE, RD, MRG, WR} state_t;

    state_t              state, state_nxt;
    logic                prio;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_data;
    logic                lat_half;

    logic                a_win, b_win, take, drop;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [1:0]          sel_size;
    logic [DATA_W-1:0]   mask, merged;

    // Winner selection: a lone valid requester always wins; on contention the
    // holder of prio wins.
    always_comb begin
        a_win    = a_valid && (!b_valid || !prio);
        b_win    = b_valid && (!a_valid || prio);
        sel_addr = b_win ? b_addr : a_addr;
        sel_data = b_win ? b_data : a_data;
        sel_size = b_win ? b_size : a_size;
        take     = (state == IDLE) && (a_win || b_win);
        drop     = (sel_addr == '0);
    end

    // Mask-based merge keeps the untouched upper bits of the old register value.
    always_comb begin
        mask   = lat_half ? DATA_W'(16'hFFFF) : DATA_W'(8'hFF);
        merged = (rf_rdata & ~mask) | (lat_data & mask);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (take && !drop) state_nxt = sel_size[1] ? WR : RD;
            RD:   state_nxt = MRG;
            MRG:  state_nxt = WR;
            WR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        a_ready = (state == IDLE) && a_win;
        b_ready = (state == IDLE) && b_win;
        rf_re   = (state == RD);
        rf_we   = (state == WR);
        busy    = (state != IDLE);
    end

    // Datapath: request latches, register-file address/data and the write counter.
    // Port address/data registers only change when a new access is set up, so they
    // hold their last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio     <= INIT_PRIO;
            lat_addr <= '0;
            lat_data <= '0;
            lat_half <= 1'b0;
            rf_raddr <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        prio     <= ~prio;
                        lat_addr <= sel_addr;
                        lat_data <= sel_data;
                        lat_half <= sel_size[0];
                        if (!drop) begin
                            if (sel_size[1]) begin
                                rf_waddr <= sel_addr;
                                rf_wdata <= sel_data;
                            end else begin
                                rf_raddr <= sel_addr;
                            end
                        end
                    end
                end
                MRG: begin
                    lat_data <= merged;
                    rf_waddr <= lat_addr;
                    rf_wdata <= merged;
                end
                WR: wr_count <= wr_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr = '0, b_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic [1:0]  a_size = '0, b_size = '0;
    logic        rf_re, rf_we, busy;
    logic [4:0]  rf_raddr, rf_waddr;
    logic [31:0] rf_rdata = '0;
    logic [31:0] rf_wdata;
    logic [15:0] wr_count;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .INIT_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data), .a_size(a_size),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data), .b_size(b_size),
        .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file model: one-cycle read latency
    logic [31:0] mem [32];
    always @(posedge clk) begin
        if (rf_re) rf_rdata <= mem[rf_raddr];
        if (rf_we) mem[rf_waddr] <= rf_wdata;
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    bit  exp_g[$];
    int  n_chk = 0, n_fail = 0;
    int  n_busy = 0, n_re = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected writes and grants when the DUT presents them
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (busy)  n_busy++;
            if (rf_re) n_re++;
            if (rf_we) begin
                if (exp_q.size() == 0) check("unexpected_write", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    check("waddr", rf_waddr, e.addr);
                    check("wdata", rf_wdata, e.data);
                    check("we_cycle", cyc, e.cyc);
                end
            end
            if (a_ready || b_ready) begin
                check("one_ready", a_ready && b_ready, 0);
                if (exp_g.size() == 0) check("unexpected_grant", exp_g.size(), 1);
                else check("grant_side", b_ready, exp_g.pop_front());
            end
        end
    end

    // Issue one request; call at posedge+#1. Pushes the expected write at accept time.
    task automatic req(bit side, logic [4:0] addr, logic [31:0] data, logic [1:0] size,
                       logic [31:0] wexp, bit expect_wr, bit check_immediate);
        int lat = size[1] ? 1 : 3;
        int waits = 0;
        bit got = 0;
        if (!side) begin a_addr = addr; a_data = data; a_size = size; a_valid = 1'b1; end
        else       begin b_addr = addr; b_data = data; b_size = size; b_valid = 1'b1; end
        while (!got && waits < 60) begin
            @(negedge clk);
            if (rst_n && (side ? b_ready : a_ready)) got = 1;
            else waits++;
        end
        check("handshake", got, 1);
        if (got && check_immediate) check("ready_latency", waits, 0);
        if (got && expect_wr && addr != 0) exp_q.push_back('{addr: addr, data: wexp, cyc: cyc + lat});
        @(posedge clk); #1;
        if (!side) a_valid = 1'b0; else b_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int nb, nr;
    logic [15:0] wc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_re", rf_re, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_raddr", rf_raddr, 0);
        check("rst_ready", {a_ready, b_ready}, 0);
        rst_n = 1'b1;
        idle(1);

        // Word write
        exp_g.push_back(0);
        req(0, 5'd5, 32'hDEADBEEF, 2'b10, 32'hDEADBEEF, 1, 1);
        idle(1);
        check("wr_count_1", wr_count, 1);
        idle(1);

        // Seed registers, then byte / half RMW
        exp_g.push_back(0); req(0, 5'd7, 32'h12345678, 2'b11, 32'h12345678, 1, 1); idle(2);
        exp_g.push_back(1); req(1, 5'd9, 32'hFFFF0000, 2'b10, 32'hFFFF0000, 1, 1); idle(2);
        exp_g.push_back(1); req(1, 5'd7, 32'h000000AB, 2'b00, 32'h123456AB, 1, 1); idle(4);
        exp_g.push_back(0); req(0, 5'd9, 32'h0000BEEF, 2'b01, 32'hFFFFBEEF, 1, 1); idle(4);
        exp_g.push_back(1); req(1, 5'd9, 32'hFFFFFF5A, 2'b00, 32'hFFFFBE5A, 1, 1); idle(4);
        check("wr_count_6", wr_count, 6);

        // Writes to $zero
        nb = n_busy; nr = n_re; wc = wr_count;
        exp_g.push_back(0); req(0, 5'd0, 32'h11111111, 2'b10, 32'h0, 1, 1);
        exp_g.push_back(0); req(0, 5'd0, 32'h22222222, 2'b00, 32'h0, 1, 1);
        idle(4);
        check("zero_busy", n_busy - nb, 0);
        check("zero_re", n_re - nr, 0);
        check("zero_wr_count", wr_count, wc);

        // Contention from reset
        rst_n = 1'b0;
        idle(1);
        exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(0); exp_g.push_back(1);
        fork
            begin
                req(0, 5'd10, 32'hA0A0A0A0, 2'b10, 32'hA0A0A0A0, 1, 0);
                req(0, 5'd12, 32'hA1A1A1A1, 2'b10, 32'hA1A1A1A1, 1, 0);
            end
            begin
                req(1, 5'd11, 32'hB0B0B0B0, 2'b10, 32'hB0B0B0B0, 1, 0);
                req(1, 5'd13, 32'hB1B1B1B1, 2'b10, 32'hB1B1B1B1, 1, 0);
            end
            begin
                idle(2);
                rst_n = 1'b1;
            end
        join
        idle(3);
        check("contention_wr_count", wr_count, 4);

        // Reset while in MRG
        exp_g.push_back(1);
        req(1, 5'd7, 32'h000000CD, 2'b00, 32'h0, 0, 1);
        check("rmw_rd_strobe", rf_re, 1);
        @(posedge clk); #2;
        check("rmw_busy_in_mrg", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_we", rf_we, 0);
        check("midrst_re", rf_re, 0);
        idle(3);
        rst_n = 1'b1;
        check("midrst_wr_count", wr_count, 0);
        check("midrst_wdata", rf_wdata, 0);
        idle(1);
        exp_g.push_back(0);
        req(0, 5'd7, 32'h00000011, 2'b00, 32'h12345611, 1, 1);
        idle(5);
        check("post_rst_wr_count", wr_count, 1);

        check("exp_writes_left", exp_q.size(), 0);
        check("exp_grants_left", exp_g.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
